// File: rtl/pe_issue.sv
// Issue stage between scheduler and PE: one-deep output register, credit gating on
// in-flight work (issued -> read-released -> write-released), and a flush drain FSM.
module pe_issue #(
    parameter int MAX_INFLIGHT = 8,
    parameter int PE_INST_W    = 32,
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                 clk,
    input  logic                 s_rst_n,
    input  logic [PE_INST_W-1:0] in_insn,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [PE_INST_W-1:0] pe_insn,
    output logic                 pe_vld,
    input  logic                 pe_rdy,
    input  logic                 pe_rd_ack,
    input  logic                 pe_wr_ack,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [CW-1:0]        rd_pend,
    output logic [CW-1:0]        wr_pend,
    output logic                 rd_release,
    output logic                 wr_release,
    output logic                 idle,
    output logic                 err_underflow
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CW+1:0] MAX_C = (CW+2)'(MAX_INFLIGHT);

    state_t                 state_q;
    logic                   flush_done_q;
    logic                   pe_vld_q;
    logic [PE_INST_W-1:0]   pe_insn_q;
    logic [CW-1:0]          rd_q, rd_d;
    logic [CW-1:0]          wr_q, wr_d;
    logic                   err_q, err_d;
    logic                   rrel_q, wrel_q;
    logic                   rdy_en_q;
    logic                   hs_s, rd_ok_s, wr_ok_s, accept_s, drained_s;
    logic [CW+1:0]          occ_s;

    // Occupancy counts the held output slot too, so credit covers the whole pipe.
    assign occ_s     = {2'b00, rd_q} + {2'b00, wr_q} + {{(CW+1){1'b0}}, pe_vld_q};
    assign in_rdy    = rdy_en_q & (state_q == ST_RUN) & (~pe_vld_q | pe_rdy) & (occ_s < MAX_C);
    assign accept_s  = in_vld & in_rdy;
    assign drained_s = ~pe_vld_q & (rd_q == {CW{1'b0}}) & (wr_q == {CW{1'b0}});

    // Pending-count next state; acks with nothing to release are dropped and flagged.
    always_comb begin
        hs_s    = pe_vld_q & pe_rdy;
        rd_ok_s = pe_rd_ack & ((rd_q != {CW{1'b0}}) | hs_s);
        wr_ok_s = pe_wr_ack & (wr_q != {CW{1'b0}});
        rd_d    = rd_q + CW'(hs_s) - CW'(rd_ok_s);
        wr_d    = wr_q + CW'(rd_ok_s) - CW'(wr_ok_s);
        err_d   = err_q | (pe_rd_ack & ~rd_ok_s) | (pe_wr_ack & ~wr_ok_s);
    end

    // Counters, sticky error, release echoes and post-reset ready enable.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rd_q     <= {CW{1'b0}};
            wr_q     <= {CW{1'b0}};
            err_q    <= 1'b0;
            rrel_q   <= 1'b0;
            wrel_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            rrel_q   <= pe_rd_ack;
            wrel_q   <= pe_wr_ack;
            rdy_en_q <= 1'b1;
        end
    end

    // Output register: load on accept, clear on PE take, otherwise hold.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            pe_vld_q  <= 1'b0;
            pe_insn_q <= {PE_INST_W{1'b0}};
        end else if (accept_s) begin
            pe_vld_q  <= 1'b1;
            pe_insn_q <= in_insn;
        end else if (pe_rdy) begin
            pe_vld_q  <= 1'b0;
        end else begin
            pe_vld_q  <= pe_vld_q;
        end
    end

    // Flush FSM; flush_done is registered so it is high for exactly the DONE cycle.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    flush_done_q <= 1'b0;
                    if (flush) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drained_s) begin
                        state_q      <= ST_DONE;
                        flush_done_q <= 1'b1;
                    end else begin
                        state_q      <= ST_DRAIN;
                        flush_done_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q      <= ST_RUN;
                    flush_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= ST_RUN;
                    flush_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign pe_vld        = pe_vld_q;
    assign pe_insn       = pe_insn_q;
    assign rd_pend       = rd_q;
    assign wr_pend       = wr_q;
    assign rd_release    = rrel_q;
    assign wr_release    = wrel_q;
    assign err_underflow = err_q;
    assign flush_done    = flush_done_q;
    assign idle          = drained_s;

endmodule

// File: doc/pe_issue.md
PE_ISSUE -- requirements
Module: pe_issue

Interface
REQ-001 Parameter MAX_INFLIGHT, default 8, SHALL set the maximum number of instructions between PE issue and PE write-ack (legal range 1..255).
REQ-002 Parameter PE_INST_W, default from hpu_common_instruction_pkg, SHALL set the instruction width.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 s_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_insn  in  PE_INST_W  instruction from scheduler.
REQ-006 in_vld  in  1  in_insn valid.
REQ-007 in_rdy  out  1  block accepts in_insn this cycle.
REQ-008 pe_insn  out  PE_INST_W  registered instruction to PE.
REQ-009 pe_vld  out  1  pe_insn valid.
REQ-010 pe_rdy  in  1  PE accepts pe_insn.
REQ-011 pe_rd_ack  in  1  one-cycle-per-instruction read-release pulse from PE.
REQ-012 pe_wr_ack  in  1  one-cycle-per-instruction write-release pulse from PE.
REQ-013 flush  in  1  level request to drain all in-flight work.
REQ-014 flush_done  out  1  one-cycle pulse, drain complete.
REQ-015 rd_pend  out  CW=$clog2(MAX_INFLIGHT+1)  instructions issued to PE, not yet rd-acked.
REQ-016 wr_pend  out  CW  instructions rd-acked, not yet wr-acked.
REQ-017 rd_release / wr_release  out  1 each  registered copies of pe_rd_ack / pe_wr_ack, one cycle late, for the scheduler.
REQ-018 idle  out  1  high when pe_vld=0, rd_pend=0, wr_pend=0.
REQ-019 err_underflow  out  1  sticky: ack received with no matching pending instruction.

Function
REQ-020 Output stage SHALL be a single register: loads in_insn when in_vld and in_rdy; holds pe_insn/pe_vld stable while pe_vld and !pe_rdy.
REQ-021 in_rdy SHALL equal (state==RUN) and (!pe_vld or pe_rdy) and (rd_pend + wr_pend + pe_vld < MAX_INFLIGHT), using current registered counts; acks free credit the following cycle (no same-cycle bypass).
REQ-022 Latency in_vld&in_rdy to pe_vld SHALL be 1 cycle; back-to-back throughput of 1 per cycle when credit is available and pe_rdy=1.
REQ-023 rd_pend SHALL update as +1 on pe_vld&pe_rdy, -1 on pe_rd_ack; both in one cycle -> unchanged.
REQ-024 wr_pend SHALL update as +1 on valid pe_rd_ack, -1 on pe_wr_ack; both in one cycle -> unchanged.
REQ-025 pe_rd_ack with rd_pend=0 (and no same-cycle PE handshake) SHALL be ignored by counters and set err_underflow.
REQ-026 pe_wr_ack with wr_pend=0 SHALL be ignored by wr_pend and set err_underflow, even if pe_rd_ack is high in the same cycle.
REQ-027 rd_release/wr_release SHALL follow pe_rd_ack/pe_wr_ack by exactly 1 cycle, including ignored acks.
REQ-028 FSM states RUN, DRAIN, DONE; RUN->DRAIN when flush=1; DRAIN->DONE when pe_vld=0, rd_pend=0, wr_pend=0; DONE->RUN unconditionally next cycle.
REQ-029 In DRAIN, the already-held pe_insn SHALL still be presented until accepted; no new input accepted.
REQ-030 flush_done SHALL be high exactly in the DONE cycle; flush asserted in RUN while already idle SHALL still pass through DRAIN (1 cycle) then DONE.
REQ-031 flush held high SHALL re-enter DRAIN from RUN after each DONE; flush dropping during DRAIN SHALL not abort the drain.
REQ-032 Counters SHALL never exceed MAX_INFLIGHT nor wrap below 0.

Reset
REQ-033 While s_rst_n=0, asynchronously: pe_vld=0, pe_insn=0, in_rdy=0, rd_pend=0, wr_pend=0, rd_release=0, wr_release=0, flush_done=0, err_underflow=0, state=RUN; idle=1.
REQ-034 Reset asserted mid-operation SHALL discard the held instruction and all pending counts; acks arriving in the first cycle after release SHALL be treated per REQ-025/026.
REQ-035 in_rdy SHALL first assert in the first rising edge after s_rst_n deasserts.

Verification
REQ-036 MAX_INFLIGHT=8, pe_rdy=1, no acks, in_vld=1 continuous -> exactly 8 PE handshakes, then in_rdy=0, rd_pend=8.
REQ-037 From rd_pend=8: 8 pe_rd_ack pulses then 8 pe_wr_ack -> rd_pend 8->0, wr_pend 0->8->0, in_rdy re-asserts cycle after first wr_ack, rd/wr_release lag by 1.
REQ-038 pe_rdy=0 for 5 cycles with pe_vld=1 -> pe_insn constant, in_rdy=0, rd_pend unchanged.
REQ-039 Same-cycle PE handshake + pe_rd_ack + pe_wr_ack with rd_pend=2, wr_pend=1 -> rd_pend=2, wr_pend=1, no error.
REQ-040 pe_wr_ack with wr_pend=0 -> err_underflow=1 and stays 1 until reset; counts unchanged.
REQ-041 flush with rd_pend=3 -> in_rdy=0, flush_done pulses 1 cycle after last wr_ack clears wr_pend, then in_rdy returns.
